// File: rtl/alu_seq.sv
// alu_seq: registered ALU with Z/N/V flags, shifts and an iterative
// shift-add multiplier, driven by a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   out_q, out_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               v_q, v_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_sum;
  logic               last_iter;
  logic               accept;
  logic               is_mul;

  assign accept    = (state_q == IDLE) && start;
  assign is_mul    = (ALUop == OP_MUL);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle result and overflow for every non-multiply op
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (ALUop)
      OP_ADD: begin
        alu_res = Ain + Bin;
        alu_v   = (Ain[MSB] == Bin[MSB]) &&
                  (alu_res[MSB] != Ain[MSB]);
      end
      OP_SUB: begin
        alu_res = Ain - Bin;
        alu_v   = (Ain[MSB] != Bin[MSB]) &&
                  (alu_res[MSB] != Ain[MSB]);
      end
      OP_AND: alu_res = Ain & Bin;
      OP_NOT: alu_res = ~Bin;
      OP_LSL: alu_res = {Bin[MSB-1:0], 1'b0};
      OP_LSR: alu_res = {1'b0, Bin[MSB:1]};
      OP_ASR: alu_res = {Bin[MSB], Bin[MSB:1]};
      default: alu_res = '0;
    endcase
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      out_q    <= '0;
      z_q      <= 1'b1;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Next state: enter MUL on an accepted multiply, leave after WIDTH steps
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && is_mul) state_d = MUL;
      MUL:  if (last_iter) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs, flags and multiplier datapath
  always_comb begin
    out_d    = out_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          mcand_d  = {{WIDTH{1'b0}}, Ain};
          mplier_d = Bin;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
        end else if (accept) begin
          out_d  = alu_res;
          z_d    = (alu_res == '0);
          n_d    = alu_res[MSB];
          v_d    = alu_v;
          done_d = 1'b1;
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          out_d  = acc_sum[WIDTH-1:0];
          z_d    = (acc_sum[WIDTH-1:0] == '0);
          n_d    = acc_sum[MSB];
          v_d    = |acc_sum[2*WIDTH-1:WIDTH];
          busy_d = 1'b0;
          done_d = 1'b1;
          cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  assign out  = out_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign V    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
